// File: rtl/float_to_fixed_conv_pkg.sv
// Shared definitions for the float-to-fixed converter: FSM encoding, rounding
// modes and the exponent bias helper.
package float_to_fixed_conv_pkg;

    // Conversion FSM state encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StRound = 2'd2,
        StDone  = 2'd3
    } conv_state_e;

    // Rounding modes selected by the RND parameter.
    localparam int unsigned RND_TRUNC = 0;  // truncate toward zero
    localparam int unsigned RND_RNE   = 1;  // round to nearest, ties to even

    // Exponent bias for an ew-bit exponent field: 2^(ew-1) - 1.
    function automatic int bias(input int unsigned ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rounding, sign application and saturation of an unsigned
// fixed-point magnitude into an FW-bit two's complement result.
module fixed_round_sat
    import float_to_fixed_conv_pkg::*;
#(
    parameter int unsigned FW  = 32,
    parameter int unsigned RND = RND_TRUNC
) (
    input  logic [FW-1:0] mag,
    input  logic          guard,
    input  logic          sticky,
    input  logic          sign,
    input  logic          big,
    input  logic          nan,
    output logic [FW-1:0] result,
    output logic          ovf,
    output logic          invalid
);

    // Largest representable magnitudes for positive and negative results.
    localparam logic [FW:0] POS_MAX = {2'b00, {(FW - 1){1'b1}}};
    localparam logic [FW:0] NEG_MAX = {2'b01, {(FW - 1){1'b0}}};

    logic          round_up;
    logic [FW:0]   sum;

    // Round the magnitude, then saturate against the sign-dependent bound.
    always_comb begin
        round_up = 1'b0;
        if (RND == RND_RNE) begin
            round_up = guard & (sticky | mag[0]);
        end
        // One extra bit keeps a rounding carry visible to the range check.
        sum     = {1'b0, mag} + {{FW{1'b0}}, round_up};
        result  = '0;
        ovf     = 1'b0;
        invalid = 1'b0;
        if (nan) begin
            invalid = 1'b1;
        end else if (!sign) begin
            if (big || (sum > POS_MAX)) begin
                result = POS_MAX[FW-1:0];
                ovf    = 1'b1;
            end else begin
                result = sum[FW-1:0];
            end
        end else begin
            if (big || (sum > NEG_MAX)) begin
                result = NEG_MAX[FW-1:0];
                ovf    = 1'b1;
            end else begin
                // A magnitude of zero negates to zero; exactly 2^(FW-1) maps to the minimum.
                result = {FW{1'b0}} - sum[FW-1:0];
            end
        end
    end

endmodule

// File: rtl/float_to_fixed_conv.sv
// Multi-cycle IEEE-style float to two's complement fixed-point converter.
// Capture in IDLE, align in SHIFT, round/saturate in ROUND, handshake in DONE.
module float_to_fixed_conv
    import float_to_fixed_conv_pkg::*;
#(
    parameter int unsigned EW   = 8,
    parameter int unsigned MW   = 23,
    parameter int unsigned FW   = 32,
    parameter int unsigned FRAC = 26,
    parameter int unsigned RND  = RND_TRUNC
) (
    input  logic             CLK,
    input  logic             RST_FF,
    input  logic             Begin_FSM_FF,
    input  logic [EW+MW:0]   F,
    output logic             ACK_FF,
    output logic [FW-1:0]    RESULT,
    output logic             OVF,
    output logic             INVALID
);

    // Wide enough to hold the significand shifted by up to FW positions.
    localparam int unsigned LW     = FW + MW + 2;
    localparam int          SH_OFS = int'(FRAC) - int'(MW) - bias(EW);

    conv_state_e      state_q;
    logic [EW+MW:0]   f_q;
    logic [FW-1:0]    mag_q;
    logic             guard_q;
    logic             sticky_q;
    logic             big_q;
    logic             sign_q;
    logic             nan_q;
    logic [FW-1:0]    result_q;
    logic             ovf_q;
    logic             invalid_q;

    logic             sign_w;
    logic [EW-1:0]    exp_w;
    logic [MW-1:0]    man_w;
    logic             exp_zero;
    logic             exp_ones;
    logic             nan_w;
    int               sh;
    logic [LW-1:0]    sig_ext;
    logic [LW-1:0]    shifted;
    logic [LW-1:0]    guard_vec;
    logic [LW-1:0]    low_mask;
    logic [FW-1:0]    sh_mag;
    logic             sh_guard;
    logic             sh_sticky;
    logic             sh_big;

    logic [FW-1:0]    rs_result;
    logic             rs_ovf;
    logic             rs_invalid;

    assign {sign_w, exp_w, man_w} = f_q;
    assign exp_zero = ~|exp_w;
    assign exp_ones = &exp_w;
    assign nan_w    = exp_ones & (|man_w);

    // Align {1,mantissa} to the fixed-point grid and collect guard/sticky bits.
    always_comb begin
        sh_mag    = '0;
        sh_guard  = 1'b0;
        sh_sticky = 1'b0;
        sh_big    = 1'b0;
        shifted   = '0;
        guard_vec = '0;
        low_mask  = '0;
        sig_ext   = LW'({1'b1, man_w});
        sh        = int'(exp_w) + SH_OFS;
        if (exp_zero) begin
            // Zero and subnormals flush to zero.
        end else if (exp_ones) begin
            // Infinity saturates; NaN is flagged separately.
            sh_big = ~|man_w;
        end else if (sh >= 0) begin
            if (sh + int'(MW) >= int'(FW)) begin
                sh_big = 1'b1;
            end else begin
                shifted = sig_ext << sh;
                sh_mag  = shifted[FW-1:0];
            end
        end else if (-sh >= int'(MW) + 2) begin
            sh_sticky = |man_w;
        end else begin
            shifted   = sig_ext >> (-sh);
            sh_mag    = shifted[FW-1:0];
            sh_big    = |shifted[LW-1:FW];
            guard_vec = sig_ext >> (-sh - 1);
            sh_guard  = guard_vec[0];
            low_mask  = (LW'(1) << (-sh - 1)) - LW'(1);
            sh_sticky = |(sig_ext & low_mask);
        end
    end

    fixed_round_sat #(
        .FW  (FW),
        .RND (RND)
    ) u_round_sat (
        .mag     (mag_q),
        .guard   (guard_q),
        .sticky  (sticky_q),
        .sign    (sign_q),
        .big     (big_q),
        .nan     (nan_q),
        .result  (rs_result),
        .ovf     (rs_ovf),
        .invalid (rs_invalid)
    );

    // Conversion FSM with all datapath and output registers.
    always_ff @(posedge CLK or posedge RST_FF) begin
        if (RST_FF) begin
            state_q   <= StIdle;
            f_q       <= '0;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            big_q     <= 1'b0;
            sign_q    <= 1'b0;
            nan_q     <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Begin_FSM_FF) begin
                        f_q     <= F;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    mag_q    <= sh_mag;
                    guard_q  <= sh_guard;
                    sticky_q <= sh_sticky;
                    big_q    <= sh_big;
                    sign_q   <= sign_w;
                    nan_q    <= nan_w;
                    state_q  <= StRound;
                end
                StRound: begin
                    result_q  <= rs_result;
                    ovf_q     <= rs_ovf;
                    invalid_q <= rs_invalid;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (!Begin_FSM_FF) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ACK_FF  = (state_q == StDone);
    assign RESULT  = result_q;
    assign OVF     = ovf_q;
    assign INVALID = invalid_q;

endmodule

// File: tb/tb_float_to_fixed_conv.sv
// Directed bench: a truncating and a round-to-nearest-even converter share the
// same stimulus; a vector table covers the arithmetic, hand sequences cover
// handshake, latency and reset behaviour.
module tb_float_to_fixed_conv;

    typedef struct {
        logic [31:0] f;
        logic [31:0] exp_t;    // expected RESULT, truncating instance
        logic [31:0] exp_r;    // expected RESULT, RNE instance
        logic        exp_ovf;
        logic        exp_inv;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] f;
    logic        ack_t, ack_r;
    logic [31:0] res_t, res_r;
    logic        ovf_t, ovf_r;
    logic        inv_t, inv_r;

    int passed;
    int total;

    float_to_fixed_conv #(
        .EW (8), .MW (23), .FW (32), .FRAC (26), .RND (0)
    ) dut_t (
        .CLK          (clk),
        .RST_FF       (rst),
        .Begin_FSM_FF (start),
        .F            (f),
        .ACK_FF       (ack_t),
        .RESULT       (res_t),
        .OVF          (ovf_t),
        .INVALID      (inv_t)
    );

    float_to_fixed_conv #(
        .EW (8), .MW (23), .FW (32), .FRAC (26), .RND (1)
    ) dut_r (
        .CLK          (clk),
        .RST_FF       (rst),
        .Begin_FSM_FF (start),
        .F            (f),
        .ACK_FF       (ack_r),
        .RESULT       (res_r),
        .OVF          (ovf_r),
        .INVALID      (inv_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One conversion with a single-cycle Begin pulse; F is scrambled after capture.
    task automatic run_conv(input vec_t v, input int idx);
        @(negedge clk);
        f     = v.f;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        f     = 32'h7FC00000;
        check($sformatf("v%0d ack_after_capture", idx), {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d ack_after_shift", idx), {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d ack_t", idx), {31'b0, ack_t}, 32'd1);
        check($sformatf("v%0d ack_r", idx), {31'b0, ack_r}, 32'd1);
        check($sformatf("v%0d result_trunc", idx), res_t, v.exp_t);
        check($sformatf("v%0d result_rne", idx), res_r, v.exp_r);
        check($sformatf("v%0d ovf_trunc", idx), {31'b0, ovf_t}, {31'b0, v.exp_ovf});
        check($sformatf("v%0d ovf_rne", idx), {31'b0, ovf_r}, {31'b0, v.exp_ovf});
        check($sformatf("v%0d invalid_trunc", idx), {31'b0, inv_t}, {31'b0, v.exp_inv});
        check($sformatf("v%0d invalid_rne", idx), {31'b0, inv_r}, {31'b0, v.exp_inv});
        @(posedge clk); #1;
        check($sformatf("v%0d ack_pulse_len", idx), {31'b0, ack_t}, 32'd0);
        check($sformatf("v%0d result_hold", idx), res_t, v.exp_t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [17];
        int   cnt;

        vecs[0]  = '{32'h3F800000, 32'h04000000, 32'h04000000, 1'b0, 1'b0}; // 1.0
        vecs[1]  = '{32'hC0200000, 32'hF6000000, 32'hF6000000, 1'b0, 1'b0}; // -2.5
        vecs[2]  = '{32'h42800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0}; // 64.0
        vecs[3]  = '{32'hFF800000, 32'h80000000, 32'h80000000, 1'b1, 1'b0}; // -Inf
        vecs[4]  = '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0}; // +Inf
        vecs[5]  = '{32'h32400000, 32'h00000000, 32'h00000001, 1'b0, 1'b0}; // 1.5*2^-27
        vecs[6]  = '{32'h32000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0}; // tie to even 0
        vecs[7]  = '{32'h7FC00000, 32'h00000000, 32'h00000000, 1'b0, 1'b1}; // NaN
        vecs[8]  = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0}; // subnormal
        vecs[9]  = '{32'hC2000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0}; // -32 exact min
        vecs[10] = '{32'h42000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0}; // +32 overflows
        vecs[11] = '{32'hB2400000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0}; // -1.5*2^-27
        vecs[12] = '{32'h3F400000, 32'h03000000, 32'h03000000, 1'b0, 1'b0}; // 0.75
        vecs[13] = '{32'hB0000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0}; // tiny negative
        vecs[14] = '{32'h32C00000, 32'h00000001, 32'h00000002, 1'b0, 1'b0}; // tie to even up
        vecs[15] = '{32'hFFC00000, 32'h00000000, 32'h00000000, 1'b0, 1'b1}; // negative NaN
        vecs[16] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0}; // -0

        passed = 0;
        total  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        f      = '0;

        // Reset state.
        #12;
        check("reset ack", {31'b0, ack_t}, 32'd0);
        check("reset result", res_t, 32'd0);
        check("reset ovf", {31'b0, ovf_t}, 32'd0);
        check("reset invalid", {31'b0, inv_r}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle no ack", {31'b0, ack_t}, 32'd0);

        // Table-driven conversions.
        for (int i = 0; i < 17; i++) begin
            run_conv(vecs[i], i);
        end

        // Begin held for 10 cycles in DONE: ACK stays high, no re-capture.
        @(negedge clk);
        f     = 32'h3F800000;
        start = 1'b1;
        @(posedge clk); #1;
        f = 32'h42800000;
        check("held ack_after_capture", {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check("held ack_after_shift", {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check("held ack_rise", {31'b0, ack_t}, 32'd1);
        check("held result", res_t, 32'h04000000);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack_t) cnt++;
        end
        check("held ack cycles", cnt, 32'd10);
        check("held no recapture result", res_t, 32'h04000000);
        check("held no recapture ovf", {31'b0, ovf_t}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("held release ack", {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check("held idle ack", {31'b0, ack_t}, 32'd0);

        // Reset asserted during SHIFT clears outputs without a clock edge.
        @(negedge clk);
        f     = 32'h3F400000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async reset ack", {31'b0, ack_t}, 32'd0);
        check("async reset result", res_t, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_t) cnt++;
        end
        check("aborted no ack", cnt, 32'd0);
        check("aborted result", res_t, 32'd0);

        // Begin high at reset release is captured on the first edge.
        @(negedge clk);
        rst   = 1'b1;
        f     = 32'hC0200000;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("release ack_after_capture", {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check("release ack_after_shift", {31'b0, ack_t}, 32'd0);
        @(posedge clk); #1;
        check("release ack", {31'b0, ack_t}, 32'd1);
        check("release result", res_t, 32'hF6000000);
        start = 1'b0;
        @(posedge clk); #1;
        check("release ack drop", {31'b0, ack_t}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
